apb_slave_mem: RTL and testbench

- APB slave sitting directly downstream of the team's APB master.
- Consumes psel/penable/paddr/pwrite/pwdata and returns pready/prdata/pslverr.
- Backs a byte-wide register memory, with a programmable number of wait states.
- Flags out-of-range addresses and master protocol violations.

---
 rtl/apb_pkg.sv | 10 +
 rtl/apb_slave_regfile.sv | 28 ++
 rtl/apb_slave_mem.sv | 115 +++++++++++
 tb/tb_apb_slave_mem.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB state encoding and bus width defaults
package apb_pkg;
   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } apb_state_e;

   localparam int APB_ADDR_W = 9;
   localparam int APB_DATA_W = 8;
endpackage

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - DEPTH x DATA_W register array, one sync write port, one comb read port
module apb_slave_regfile #(
   parameter int DEPTH  = 64,
   parameter int DATA_W = 8,
   parameter int IDX_W  = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              we,
   input  logic [IDX_W-1:0]  waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [IDX_W-1:0]  raddr,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/apb_slave_mem.sv
// rtl/apb_slave_mem.sv - APB slave over a byte register memory with programmable wait states
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int ADDR_W      = APB_ADDR_W,
   parameter int DATA_W      = APB_DATA_W,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              psel,
   input  logic              penable,
   input  logic [ADDR_W-1:0] paddr,
   input  logic              pwrite,
   input  logic [DATA_W-1:0] pwdata,
   output logic              pready,
   output logic [DATA_W-1:0] prdata,
   output logic              pslverr,
   output logic              proto_err
);
   localparam int IDX_W = $clog2(DEPTH);
   localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WAIT_CYCLES);
   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W + 1)'(DEPTH);

   apb_state_e        state, state_n;
   logic [CNT_W-1:0]  cnt, cnt_n;
   logic [ADDR_W-1:0] addr_q, addr_n;
   logic              write_q, write_n;
   logic [DATA_W-1:0] wdata_q, wdata_n;
   logic              proto_err_n;

   logic              dropped, range_err, stab_err, xfer_err, we;
   logic [DATA_W-1:0] rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         write_q   <= 1'b0;
         wdata_q   <= '0;
         proto_err <= 1'b0;
      end else begin
         state     <= state_n;
         cnt       <= cnt_n;
         addr_q    <= addr_n;
         write_q   <= write_n;
         wdata_q   <= wdata_n;
         proto_err <= proto_err_n;
      end
   end

   // pready comes only from registered state so the master never sees a comb loop through us
   assign pready    = (state == ACCESS) && (cnt == '0);
   assign dropped   = !psel || !penable;
   assign range_err = {1'b0, addr_q} >= DEPTH_V;
   assign stab_err  = (paddr != addr_q) || (pwrite != write_q) || (pwdata != wdata_q);
   assign xfer_err  = range_err || stab_err || dropped;
   assign we        = pready && write_q && !xfer_err;

   assign pslverr = pready && xfer_err;
   assign prdata  = (pready && !write_q && !xfer_err) ? rdata : '0;

   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      addr_n      = addr_q;
      write_n     = write_q;
      wdata_n     = wdata_q;
      proto_err_n = proto_err;
      case (state)
         IDLE: begin
            if (penable) begin
               proto_err_n = 1'b1;
            end else if (psel) begin
               state_n = ACCESS;
               cnt_n   = CNT_LOAD;
               addr_n  = paddr;
               write_n = pwrite;
               wdata_n = pwdata;
            end
         end
         ACCESS: begin
            if (dropped) begin
               proto_err_n = 1'b1;
               state_n     = IDLE;
            end else if (cnt != '0) begin
               cnt_n = cnt - 1'b1;
            end else begin
               state_n = IDLE;
               if (stab_err) begin
                  proto_err_n = 1'b1;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   apb_slave_regfile #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W)
   ) u_regfile (
      .clk    (clk),
      .resetn (resetn),
      .we     (we),
      .waddr  (addr_q[IDX_W-1:0]),
      .wdata  (wdata_q),
      .raddr  (addr_q[IDX_W-1:0]),
      .rdata  (rdata)
   );
endmodule

// File: tb/tb_apb_slave_mem.sv
// tb/tb_apb_slave_mem.sv - directed bench over three slaves with 0, 1 and 2 wait states
module tb_apb_slave_mem;
   logic       clk;
   logic       resetn;
   logic       psel_b, penable_b;
   logic [8:0] paddr;
   logic       pwrite;
   logic [7:0] pwdata;
   int         sel;
   int         total, bad;

   logic       psel_v [3];
   logic       penable_v [3];
   logic       pready_v [3];
   logic [7:0] prdata_v [3];
   logic       pslverr_v [3];
   logic       proto_err_v [3];

   logic       pready_m, pslverr_m, proto_err_m;
   logic [7:0] prdata_m;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < 3; i++) begin
         psel_v[i]    = psel_b && (sel == i);
         penable_v[i] = penable_b && (sel == i);
      end
      pready_m    = pready_v[sel];
      prdata_m    = prdata_v[sel];
      pslverr_m   = pslverr_v[sel];
      proto_err_m = proto_err_v[sel];
   end

   apb_slave_mem #(.ADDR_W(9), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(0)) u_w0 (
      .clk(clk), .resetn(resetn), .psel(psel_v[0]), .penable(penable_v[0]),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pready(pready_v[0]),
      .prdata(prdata_v[0]), .pslverr(pslverr_v[0]), .proto_err(proto_err_v[0]));

   apb_slave_mem #(.ADDR_W(9), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(1)) u_w1 (
      .clk(clk), .resetn(resetn), .psel(psel_v[1]), .penable(penable_v[1]),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pready(pready_v[1]),
      .prdata(prdata_v[1]), .pslverr(pslverr_v[1]), .proto_err(proto_err_v[1]));

   apb_slave_mem #(.ADDR_W(9), .DATA_W(8), .DEPTH(64), .WAIT_CYCLES(2)) u_w2 (
      .clk(clk), .resetn(resetn), .psel(psel_v[2]), .penable(penable_v[2]),
      .paddr(paddr), .pwrite(pwrite), .pwdata(pwdata), .pready(pready_v[2]),
      .prdata(prdata_v[2]), .pslverr(pslverr_v[2]), .proto_err(proto_err_v[2]));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1 resetn = 1'b1;
   endtask

   // s selects the slave, whose wait-state count equals s
   task automatic xfer(input int s, input logic w, input logic [8:0] a, input logic [7:0] d,
                       input logic [7:0] exp_rd, input logic exp_err, input string tag);
      int n;
      sel = s; psel_b = 1'b1; penable_b = 1'b0; paddr = a; pwrite = w; pwdata = d;
      #1 chk({tag, "_setup_rdy"}, 32'(pready_m), 32'd0);
      @(posedge clk); #1;
      penable_b = 1'b1;
      n = 1;
      #1;
      while (!pready_m && n < 20) begin
         @(posedge clk); #2;
         n++;
      end
      chk({tag, "_lat"}, 32'(n), 32'(s + 1));
      chk({tag, "_err"}, 32'(pslverr_m), 32'(exp_err));
      if (!w) chk({tag, "_rd"}, 32'(prdata_m), 32'(exp_rd));
      @(posedge clk); #1;
      psel_b = 1'b0; penable_b = 1'b0;
   endtask

   initial begin
      total = 0; bad = 0; sel = 1;
      resetn = 1'b0; psel_b = 1'b0; penable_b = 1'b0;
      paddr = '0; pwrite = 1'b0; pwdata = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pready", 32'(pready_m), 32'd0);
      chk("rst_prdata", 32'(prdata_m), 32'd0);
      chk("rst_pslverr", 32'(pslverr_m), 32'd0);
      chk("rst_proto", 32'(proto_err_m), 32'd0);
      resetn = 1'b1;

      xfer(1, 1'b1, 9'h010, 8'hA5, 8'h00, 1'b0, "w1_wr10");
      xfer(1, 1'b0, 9'h010, 8'h00, 8'hA5, 1'b0, "w1_rd10");

      xfer(0, 1'b1, 9'h000, 8'h3C, 8'h00, 1'b0, "w0_wr00");
      xfer(0, 1'b0, 9'h000, 8'h00, 8'h3C, 1'b0, "w0_rd00");
      xfer(0, 1'b0, 9'h000, 8'h00, 8'h3C, 1'b0, "w0_rd00b");
      chk("w0_proto", 32'(proto_err_m), 32'd0);

      do_reset();
      xfer(1, 1'b1, 9'h050, 8'h77, 8'h00, 1'b1, "w1_oor_wr");
      xfer(1, 1'b0, 9'h010, 8'h00, 8'h00, 1'b0, "w1_alias_rd");
      xfer(1, 1'b0, 9'h1FF, 8'h00, 8'h00, 1'b1, "w1_oor_rd");
      xfer(1, 1'b0, 9'h03F, 8'h00, 8'h00, 1'b0, "w1_top_rd");
      chk("w1_oor_proto", 32'(proto_err_m), 32'd0);

      // paddr moves mid-transfer on the two-wait slave
      xfer(2, 1'b1, 9'h004, 8'h11, 8'h00, 1'b0, "w2_pre4");
      xfer(2, 1'b1, 9'h005, 8'h22, 8'h00, 1'b0, "w2_pre5");
      chk("w2_pre_proto", 32'(proto_err_m), 32'd0);
      sel = 2; psel_b = 1'b1; penable_b = 1'b0; paddr = 9'h004; pwrite = 1'b1; pwdata = 8'h99;
      @(posedge clk); #1 penable_b = 1'b1;
      @(posedge clk); #1 paddr = 9'h005;
      @(posedge clk); #1;
      chk("stab_pready", 32'(pready_m), 32'd1);
      chk("stab_pslverr", 32'(pslverr_m), 32'd1);
      @(posedge clk); #1 psel_b = 1'b0; penable_b = 1'b0;
      #1 chk("stab_proto", 32'(proto_err_m), 32'd1);
      xfer(2, 1'b0, 9'h004, 8'h00, 8'h11, 1'b0, "stab_rd4");
      xfer(2, 1'b0, 9'h005, 8'h00, 8'h22, 1'b0, "stab_rd5");

      // master drops penable in the first access cycle
      do_reset();
      chk("abort_pre_proto", 32'(proto_err_m), 32'd0);
      sel = 2; psel_b = 1'b1; penable_b = 1'b0; paddr = 9'h020; pwrite = 1'b1; pwdata = 8'h5A;
      @(posedge clk); #1 penable_b = 1'b0;
      #1 chk("abort_rdy_a1", 32'(pready_m), 32'd0);
      @(posedge clk); #1 psel_b = 1'b0;
      #1 chk("abort_rdy_idle", 32'(pready_m), 32'd0);
      chk("abort_proto", 32'(proto_err_m), 32'd1);
      xfer(2, 1'b0, 9'h020, 8'h00, 8'h00, 1'b0, "abort_rd20");

      // reset lands while the write is still waiting
      sel = 1; psel_b = 1'b1; penable_b = 1'b0; paddr = 9'h008; pwrite = 1'b1; pwdata = 8'hFF;
      @(posedge clk); #1 penable_b = 1'b1;
      #2 resetn = 1'b0;
      #1;
      chk("mid_rst_pready", 32'(pready_m), 32'd0);
      chk("mid_rst_pslverr", 32'(pslverr_m), 32'd0);
      chk("mid_rst_prdata", 32'(prdata_m), 32'd0);
      psel_b = 1'b0; penable_b = 1'b0;
      @(posedge clk); @(posedge clk); #1 resetn = 1'b1;
      xfer(1, 1'b0, 9'h008, 8'h00, 8'h00, 1'b0, "mid_rst_rd08");
      chk("mid_rst_proto", 32'(proto_err_m), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
